// File: rtl/flash_pkg.sv
// -----------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the flash read arbiter: FSM state encoding, the
// default byte timeout, and the burst length decoding helper.
// -----------------------------------------------------------------------------
package flash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Cycles allowed between rd_read and rd_ready before a byte is failed.
    localparam int TIMEOUT_DEF = 64;

    localparam int LEN_W = 8;
    // One extra bit so a full 256-byte burst is representable.
    localparam int CNT_W = LEN_W + 1;

    // A length field of zero encodes the maximum burst of 256 bytes.
    function automatic logic [CNT_W-1:0] burst_count(input logic [LEN_W-1:0] len);
        return (len == '0) ? CNT_W'(256) : {1'b0, len};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin selector. The requester that was served last
// loses a tie; a lone requester always wins.
//
// Ports:
//   req   [1:0]  in   request vector
//   last         in   index of the requester served most recently
//   grant [1:0]  out  one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | last);
        grant[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// -----------------------------------------------------------------------------
// flash_read_arbiter
// Arbitrates two burst requesters onto a single byte-wide flash reader.
// A granted burst is broken into single-byte reader transactions
// (rd_read -> rd_ready); each returned byte is forwarded on rdata/rvalid.
// A burst ends with done (length exhausted or requester withdrew) or with
// err (reader did not answer within TIMEOUT cycles).
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   req0/req1            burst requests, held until done/err
//   addr0/addr1          burst start byte address, sampled at grant
//   len0/len1            burst byte count, sampled at grant (0 = 256)
//   gnt0/gnt1            current owner of the reader (one-hot or zero)
//   rvalid, rdata        one-cycle byte strobe and data for the owner
//   done, err            one-cycle end-of-burst strobes
//   rd_read, rd_addr     one-cycle start pulse and address to the reader
//   rd_ready, rd_data    reader completion strobe and byte
// -----------------------------------------------------------------------------
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ADDR_W  = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid,
    output logic [7:0]        rdata,
    output logic              done,
    output logic              err,
    output logic              rd_read,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ready,
    input  logic [7:0]        rd_data
);

    // Counter is cleared in the rd_read cycle and reads 0 in the first WAIT
    // cycle, so TIMEOUT-2 is the last WAIT cycle that may still see rd_ready;
    // err then appears exactly TIMEOUT cycles after rd_read.
    localparam int TCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 2);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    logic [TCW-1:0]    tcnt;
    logic              byte_pend;
    logic              last_srv;
    logic [1:0]        grant;
    logic              req_g;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

    rr_arb2 u_rr_arb2 (
        .req   ({req1, req0}),
        .last  (last_srv),
        .grant (grant)
    );

    assign sel_addr = grant[1] ? addr1 : addr0;
    assign sel_len  = grant[1] ? len1  : len0;
    assign req_g    = gnt1 ? req1 : req0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_read   <= 1'b0;
            rd_addr   <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            tcnt      <= '0;
            byte_pend <= 1'b0;
            // Pretend requester 1 was served last so requester 0 wins first.
            last_srv  <= 1'b1;
        end else begin
            rvalid  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rd_read <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        gnt0      <= grant[0];
                        gnt1      <= grant[1];
                        cur_addr  <= sel_addr;
                        remaining <= burst_count(sel_len);
                        // rd_read is raised on ISSUE entry so the pulse
                        // coincides with the ISSUE cycle itself.
                        rd_addr   <= sel_addr;
                        rd_read   <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    tcnt      <= '0;
                    byte_pend <= 1'b0;
                    state     <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (byte_pend) begin
                        // Byte already delivered last cycle; decide whether
                        // the burst continues.
                        byte_pend <= 1'b0;
                        if (remaining == '0 || !req_g) begin
                            done     <= 1'b1;
                            gnt0     <= 1'b0;
                            gnt1     <= 1'b0;
                            last_srv <= gnt1;
                            state    <= ST_IDLE;
                        end else begin
                            rd_addr <= cur_addr;
                            rd_read <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end else if (rd_ready) begin
                        rdata     <= rd_data;
                        rvalid    <= 1'b1;
                        remaining <= remaining - CNT_W'(1);
                        cur_addr  <= cur_addr + ADDR_W'(1);
                        byte_pend <= 1'b1;
                    end else if (tcnt == TO_LAST) begin
                        err      <= 1'b1;
                        gnt0     <= 1'b0;
                        gnt1     <= 1'b0;
                        last_srv <= gnt1;
                        state    <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_flash_read_arbiter
// Self-checking bench: a behavioural flash reader with programmable latency,
// an address queue checked on every rd_read, and an event scoreboard
// (bytes, done, err) checked on every rvalid/done/err strobe.
// -----------------------------------------------------------------------------
module tb_flash_read_arbiter;

    localparam int TO = 64;

    typedef struct {
        logic [2:0] kind;   // {err, done, rvalid}
        logic       gid;
        logic [7:0] data;
    } ev_t;

    logic        clk;
    logic        rstn;
    logic        req0, req1;
    logic [23:0] addr0, addr1;
    logic [7:0]  len0, len1;
    logic        gnt0, gnt1;
    logic        rvalid;
    logic [7:0]  rdata;
    logic        done, err;
    logic        rd_read;
    logic [23:0] rd_addr;
    logic        rd_ready;
    logic [7:0]  rd_data;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_rd  = 0;
    int last_rd_cyc = 0;
    int rd_lat = 3;
    logic rd_en = 1'b1;
    logic owner = 1'b0;

    ev_t         exp_q[$];
    logic [23:0] addr_q[$];

    flash_read_arbiter #(.TIMEOUT(TO), .ADDR_W(24)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .len0     (len0),
        .len1     (len1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .done     (done),
        .err      (err),
        .rd_read  (rd_read),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Byte the reader model returns for a given address.
    function automatic logic [7:0] rdfn(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic push_burst(input logic gid, input logic [23:0] a, input int n);
        ev_t e;
        logic [23:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 24'(i);
            addr_q.push_back(ai);
            e.kind = 3'b001;
            e.gid  = gid;
            e.data = rdfn(ai);
            exp_q.push_back(e);
        end
        e.kind = 3'b010;
        e.gid  = gid;
        e.data = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || addr_q.size() != 0) && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("drain", 32'(exp_q.size() + addr_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input int target, input int budget);
        int k;
        k = 0;
        while (n_rd < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("rd_seen", 32'(n_rd >= target), 32'd1);
        #2;
    endtask

    // Flash reader model: answers each rd_read after rd_lat cycles.
    logic        rpend = 1'b0;
    int          rcnt  = 0;
    logic [23:0] raddr = '0;
    initial begin
        rd_ready = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = 1'b0;
            if (err) rpend = 1'b0;
            if (rpend && rd_en) begin
                rcnt--;
                if (rcnt == 0) begin
                    rd_ready = 1'b1;
                    rd_data  = rdfn(raddr);
                    rpend    = 1'b0;
                end
            end
            if (rd_read && rstn) begin
                chk("rd_overlap", 32'(rpend), 32'd0);
                chk("rd_expected", 32'(addr_q.size() != 0), 32'd1);
                if (addr_q.size() != 0) chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
                rpend = 1'b1;
                rcnt  = rd_lat;
                raddr = rd_addr;
                n_rd++;
                last_rd_cyc = cyc;
            end
        end
    end

    // Output monitor / scoreboard.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (gnt0) owner = 1'b0;
            if (gnt1) owner = 1'b1;
            if (rvalid || done || err) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("evt_kind", 32'({err, done, rvalid}), 32'(e.kind));
                    if (e.kind == 3'b001) begin
                        chk("rdata", 32'(rdata), 32'(e.data));
                        chk("owner_gnt", 32'({gnt1, gnt0}), e.gid ? 32'd2 : 32'd1);
                    end else begin
                        chk("end_gnt", 32'({gnt1, gnt0}), 32'd0);
                    end
                    if (err) chk("err_lat", 32'(cyc - last_rd_cyc), 32'(TO));
                end
                if (done || err) begin
                    if (owner) req1 = 1'b0;
                    else       req0 = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t e;
        int n0;
        rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt",    32'({gnt1, gnt0}), 32'd0);
        chk("rst_strobe", 32'({rvalid, done, err, rd_read}), 32'd0);
        chk("rst_rdata",  32'(rdata), 32'd0);
        chk("rst_rdaddr", 32'(rd_addr), 32'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Simultaneous requests after reset: requester 0 first.
        rd_lat = 3;
        push_burst(1'b0, 24'h001000, 2);
        push_burst(1'b1, 24'h002000, 2);
        addr0 = 24'h001000; len0 = 8'd2; addr1 = 24'h002000; len1 = 8'd2;
        req0 = 1'b1; req1 = 1'b1;
        drain(300);

        // Single 4-byte burst with a slow reader.
        rd_lat = 24;
        push_burst(1'b0, 24'h400000, 4);
        addr0 = 24'h400000; len0 = 8'd4; req0 = 1'b1;
        drain(400);

        // Requester 0 served last: tie now goes to requester 1.
        rd_lat = 3;
        push_burst(1'b1, 24'h004000, 2);
        push_burst(1'b0, 24'h003000, 2);
        addr0 = 24'h003000; len0 = 8'd2; addr1 = 24'h004000; len1 = 8'd2;
        req0 = 1'b1; req1 = 1'b1;
        drain(300);

        // Address wrap at the top of the address space.
        push_burst(1'b1, 24'hFFFFFE, 3);
        addr1 = 24'hFFFFFE; len1 = 8'd3; req1 = 1'b1;
        drain(300);

        // len = 0 means 256 bytes.
        rd_lat = 1;
        push_burst(1'b0, 24'h100000, 256);
        addr0 = 24'h100000; len0 = 8'd0; req0 = 1'b1;
        drain(3000);

        // Requester withdraws during byte 2 of an 8-byte burst.
        rd_lat = 6;
        push_burst(1'b0, 24'h200000, 2);
        n0 = n_rd;
        addr0 = 24'h200000; len0 = 8'd8; req0 = 1'b1;
        wait_rd(n0 + 2, 300);
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b0;
        drain(300);

        // Reader never answers: err after TIMEOUT cycles, no done.
        rd_en = 1'b0;
        addr_q.push_back(24'h300000);
        e.kind = 3'b100; e.gid = 1'b1; e.data = 8'h00;
        exp_q.push_back(e);
        addr1 = 24'h300000; len1 = 8'd2; req1 = 1'b1;
        drain(300);
        rd_en = 1'b1;

        // Reset in the middle of WAIT.
        rd_lat = 20;
        addr_q.push_back(24'h500000);
        n0 = n_rd;
        addr0 = 24'h500000; len0 = 8'd4; req0 = 1'b1;
        wait_rd(n0 + 1, 100);
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_gnt", 32'({gnt1, gnt0}), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_gnt",    32'({gnt1, gnt0}), 32'd0);
        chk("arst_strobe", 32'({rvalid, done, err, rd_read}), 32'd0);
        chk("arst_rdaddr", 32'(rd_addr), 32'd0);
        chk("arst_rdata",  32'(rdata), 32'd0);
        req0 = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        // Stale rd_ready arrives in this window and must produce nothing.
        repeat (30) @(posedge clk);
        drain(10);

        // Round-robin pointer was reset: requester 0 wins again.
        rd_lat = 2;
        push_burst(1'b0, 24'h600000, 1);
        push_burst(1'b1, 24'h700000, 1);
        addr0 = 24'h600000; len0 = 8'd1; addr1 = 24'h700000; len1 = 8'd1;
        req0 = 1'b1; req1 = 1'b1;
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
